// File: rtl/cla28_arbiter.sv
// Round-robin sequencer sharing one external WIDTH-bit adder among NREQ requesters.
// Optional carry-out reporting: define CLA_ARB_CARRY_EN to add the resp_carry port.
module cla28_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_s,
  output logic                  resp_valid,
  output logic [WIDTH-1:0]      resp_sum,
  output logic [2:0]            resp_id,
`ifdef CLA_ARB_CARRY_EN
  output logic                  resp_carry,
`endif
  input  logic                  resp_ready
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;
  state_t state, nxt;

  logic [IW-1:0]              rr_ptr, gnt, idx;
  logic [IW:0]                sum_ix;
  logic                       any, hs;
  logic [NREQ-1:0][WIDTH-1:0] a_arr, b_arr;

  assign a_arr = req_a;
  assign b_arr = req_b;

  // Search rr_ptr, rr_ptr+1, ... with an explicit wrap so non-power-of-2 NREQ works.
  always_comb begin
    gnt    = '0;
    any    = 1'b0;
    sum_ix = '0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum_ix = {1'b0, rr_ptr} + (IW+1)'(i);
      if (sum_ix >= (IW+1)'(NREQ)) sum_ix = sum_ix - (IW+1)'(NREQ);
      idx = sum_ix[IW-1:0];
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        gnt = idx;
      end
    end
  end

  assign hs = (state == IDLE) && any && !rst;

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NREQ; k++)
      req_ready[k] = hs && (gnt == IW'(k));
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (hs) nxt = ADD;
      ADD:     nxt = RESP;
      RESP:    if (resp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      add_a      <= '0;
      add_b      <= '0;
      resp_valid <= 1'b0;
      resp_sum   <= '0;
      resp_id    <= '0;
`ifdef CLA_ARB_CARRY_EN
      resp_carry <= 1'b0;
`endif
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (hs) begin
          add_a   <= a_arr[gnt];
          add_b   <= b_arr[gnt];
          resp_id <= 3'(gnt);
          rr_ptr  <= (gnt == IW'(NREQ-1)) ? '0 : gnt + IW'(1);
        end
        ADD: begin
          resp_sum   <= add_s;
          resp_valid <= 1'b1;
`ifdef CLA_ARB_CARRY_EN
          // Carry recovered from the MSBs since the shared adder exposes only S.
          resp_carry <= (add_a[WIDTH-1] & add_b[WIDTH-1]) |
                        ((add_a[WIDTH-1] ^ add_b[WIDTH-1]) & ~add_s[WIDTH-1]);
`endif
        end
        RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
